axi_rd_master: RTL
==================

Name: axi_rd_master

Overview:
- AXI3-style read initiator. Sits opposite the team's AXI memory slave (my_axi_mem) and drives its AR/R channels.
- Accepts a single-burst read command on a valid/ready command port, issues one INCR burst, and streams returned beats to a consumer.
- Reports a per-burst completion pulse with worst response and error code.
- Write channels are out of scope.

Parameters:
DATA_WIDTH, 32, R data width (bits)
ADDRESS_WIDTH, 32, address width (bits)
TIMEOUT_CYCLES, 256, watchdog limit in cycles; used only with AXI_RD_TIMEOUT_EN

Ports:
aclk  in  1  clock, all logic on rising edge
arstn  in  1  reset, synchronous, active-low
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when high with cmd_valid
cmd_addr  in  ADDRESS_WIDTH  start byte address
cmd_len  in  4  beats minus 1
cmd_size  in  3  log2 bytes per beat
cmd_id  in  4  transaction ID
arvalid/arready/arid[4]/araddr[ADDRESS_WIDTH]/arlen[4]/arsize[3]/arburst[2]  AXI AR channel (arready in, rest out)
rvalid/rready/rid[4]/rdata[DATA_WIDTH]/rresp[2]/rlast  AXI R channel (rready out, rest in)
out_valid  out  1  read beat valid
out_ready  in  1  consumer ready
out_data  out  DATA_WIDTH  beat data
out_last  out  1  final expected beat
done  out  1  one-cycle completion pulse
done_resp  out  2  worst rresp of burst (OKAY=00 < EXOKAY=01 < SLVERR=10 < DECERR=11), valid with done
done_err  out  2  0 none, 1 rejected, 2 protocol, 3 timeout; valid with done

Behaviour:
- Reset (arstn=0 at a clock edge): state IDLE; all outputs 0, including cmd_ready. Reset mid-burst aborts immediately; arvalid drops; no done.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, latch the command and clear accumulators.
  - Reject if cmd_size>2, or cmd_addr is not aligned to 2^cmd_size, or the burst end (cmd_addr+(cmd_len+1)<<cmd_size-1) crosses a 4 KB boundary. Reject -> REPORT with done_err=1, no AR issued.
  - Otherwise -> ADDR.
- ADDR:
  - arvalid=1; araddr/arlen/arsize/arid are the latched values; arburst=2'b01.
  - All AR outputs stay stable until arready. On arready -> DATA, beat counter=0.
  - Minimum one cycle arvalid; first R beat is accepted no earlier than the cycle after the AR handshake.
- DATA:
  - Combinational pass-through: out_valid=rvalid, rready=out_ready, out_data=rdata.
  - out_last=(count==latched len).
  - A beat transfers when rvalid&&rready; count increments; done_resp accumulates max(rresp).
  - rid != latched id: set protocol flag, beat still forwarded.
  - rlast=1 with count<len: protocol flag, beat forwarded with out_last=1, -> REPORT.
  - Beat count==len with rlast=1: -> REPORT.
  - Beat count==len with rlast=0: protocol flag, -> DRAIN.
- DRAIN: out_valid=0, rready=1; discard beats until rlast, then -> REPORT.
- REPORT: done=1 for exactly one cycle with done_resp/done_err; -> IDLE. Protocol flag gives done_err=2; timeout overrides it (3).
- cmd_ready is 0 in every state except IDLE; the earliest next accept is the cycle after done.
- Counter width is 4 bits; cmd_len=15 gives 16 beats with no wrap.

Optional Feature:
- Macro: AXI_RD_TIMEOUT_EN.
- With the macro defined:
  - A counter runs in ADDR and DATA; it clears on every AR or R handshake.
  - Reaching TIMEOUT_CYCLES -> REPORT with done_err=3; arvalid/rready drop.
- Without it: no counter; done_err=3 never produced; TIMEOUT_CYCLES is unused.

Decomposition:
- Shared package axi_pkg holds:
  - burst constants (FIXED/INCR/WRAP)
  - resp constants (OKAY/EXOKAY/SLVERR/DECERR)
  - the done_err encoding
  - the rd_state_t enum {IDLE, ADDR, DATA, DRAIN, REPORT}
- One sub-module, axi_wdog (timeout counter), instantiated only under AXI_RD_TIMEOUT_EN.

Test Plan:
1. cmd addr=0x10, len=3, size=2, id=5; slave returns 4 beats rresp=0, rlast on 4th -> 4 out beats, out_last on 4th, done with resp=00, err=0.
2. cmd addr=0x11, size=1 (misaligned) -> no arvalid; done next-but-one cycle with err=1.
3. len=1, slave asserts rlast on beat 0 -> 1 beat out with out_last=1; done err=2.
4. len=0, slave returns rlast=0 then 2 extra beats with the last having rlast=1 -> 1 beat out; extras drained with out_valid=0; done err=2.
5. len=3, beat 2 rresp=2'b10, out_ready toggling 1/0 each cycle -> all 4 beats delivered in order; done resp=10.
6. (AXI_RD_TIMEOUT_EN, TIMEOUT_CYCLES=8) arready held 0 -> arvalid high for 8 cycles, then done err=3; cmd_ready=1 the following cycle.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI constants and the read-master state encoding.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_REJECT  = 2'd1;
    localparam logic [1:0] ERR_PROTO   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {IDLE, ADDR, DATA, DRAIN, REPORT} rd_state_t;

    // Response codes are ordered by severity, so the worst is the numeric max.
    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_wdog.sv
// Stall watchdog: counts cycles while run is high, restarts on clr, flags the limit.
module axi_wdog #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic aclk,
    input  logic arstn,
    input  logic run,
    input  logic clr,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge aclk) begin
        if (!arstn || !run || clr) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Fires on the cycle that would be the TIMEOUT_CYCLES-th without progress.
    assign expired = run && !clr && (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/axi_rd_master.sv
// AXI3 single-burst INCR read initiator with per-burst completion report.
// Optional stall watchdog enabled by defining AXI_RD_TIMEOUT_EN.
module axi_rd_master
    import axi_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                     aclk,
    input  logic                     arstn,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
    input  logic [3:0]               cmd_len,
    input  logic [2:0]               cmd_size,
    input  logic [3:0]               cmd_id,
    output logic                     arvalid,
    input  logic                     arready,
    output logic [3:0]               arid,
    output logic [ADDRESS_WIDTH-1:0] araddr,
    output logic [3:0]               arlen,
    output logic [2:0]               arsize,
    output logic [1:0]               arburst,
    input  logic                     rvalid,
    output logic                     rready,
    input  logic [3:0]               rid,
    input  logic [DATA_WIDTH-1:0]    rdata,
    input  logic [1:0]               rresp,
    input  logic                     rlast,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_last,
    output logic                     done,
    output logic [1:0]               done_resp,
    output logic [1:0]               done_err
);
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    rd_state_t state, state_n;

    logic [ADDRESS_WIDTH-1:0] lat_addr;
    logic [3:0]               lat_len;
    logic [2:0]               lat_size;
    logic [3:0]               lat_id;

    logic [3:0] count, count_n;
    logic [1:0] resp_acc, resp_n;
    logic       proto, proto_n;
    logic       reject, reject_n;
    logic       tmo, tmo_n;
    logic       take;
    logic       expired;

    // Command legality: size, alignment, and 4 KB page crossing of the last byte.
    logic        bad_cmd;
    logic        misalign;
    logic [12:0] burst_bytes;
    logic [12:0] end_off;

    always_comb begin
        burst_bytes = 13'({1'b0, cmd_len} + 5'd1) << cmd_size;
        end_off     = {1'b0, cmd_addr[11:0]} + burst_bytes - 13'd1;
        case (cmd_size)
            3'd1:    misalign = cmd_addr[0];
            3'd2:    misalign = |cmd_addr[1:0];
            default: misalign = 1'b0;
        endcase
        bad_cmd = (cmd_size > 3'd2) || misalign || end_off[12];
    end

    logic ar_hs, r_hs;
    assign ar_hs = (state == ADDR) && arready;
    assign r_hs  = ((state == DATA) && rvalid && out_ready) || ((state == DRAIN) && rvalid);

`ifdef AXI_RD_TIMEOUT_EN
    axi_wdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .aclk   (aclk),
        .arstn  (arstn),
        .run    ((state == ADDR) || (state == DATA)),
        .clr    (ar_hs || r_hs),
        .expired(expired)
    );
`else
    assign expired = 1'b0;
`endif

    always_comb begin
        state_n   = state;
        count_n   = count;
        resp_n    = resp_acc;
        proto_n   = proto;
        reject_n  = reject;
        tmo_n     = tmo;
        take      = 1'b0;
        cmd_ready = 1'b0;
        arvalid   = 1'b0;
        araddr    = '0;
        arlen     = '0;
        arsize    = '0;
        arid      = '0;
        arburst   = '0;
        rready    = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        done      = 1'b0;
        done_resp = '0;
        done_err  = '0;

        case (state)
            IDLE: begin
                cmd_ready = arstn;
                if (cmd_valid && arstn) begin
                    take     = 1'b1;
                    count_n  = '0;
                    resp_n   = RESP_OKAY;
                    proto_n  = 1'b0;
                    tmo_n    = 1'b0;
                    reject_n = bad_cmd;
                    state_n  = bad_cmd ? REPORT : ADDR;
                end
            end
            ADDR: begin
                arvalid = 1'b1;
                araddr  = lat_addr;
                arlen   = lat_len;
                arsize  = lat_size;
                arid    = lat_id;
                arburst = BURST_INCR;
                if (arready) begin
                    count_n = '0;
                    state_n = DATA;
                end else if (expired) begin
                    tmo_n   = 1'b1;
                    state_n = REPORT;
                end
            end
            DATA: begin
                out_valid = rvalid;
                rready    = out_ready;
                out_data  = rdata;
                out_last  = (count == lat_len) || (rvalid && rlast);
                if (r_hs) begin
                    count_n = count + 4'd1;
                    resp_n  = resp_max(resp_acc, rresp);
                    if (rid != lat_id) proto_n = 1'b1;
                    if (count == lat_len) begin
                        if (!rlast) proto_n = 1'b1;
                        state_n = rlast ? REPORT : DRAIN;
                    end else if (rlast) begin
                        proto_n = 1'b1;
                        state_n = REPORT;
                    end
                end else if (expired) begin
                    tmo_n   = 1'b1;
                    state_n = REPORT;
                end
            end
            DRAIN: begin
                rready = 1'b1;
                if (rvalid && rlast) state_n = REPORT;
            end
            REPORT: begin
                done      = 1'b1;
                done_resp = resp_acc;
                if (tmo)         done_err = ERR_TIMEOUT;
                else if (reject) done_err = ERR_REJECT;
                else if (proto)  done_err = ERR_PROTO;
                else             done_err = ERR_NONE;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!arstn) begin
            state    <= IDLE;
            count    <= '0;
            resp_acc <= '0;
            proto    <= 1'b0;
            reject   <= 1'b0;
            tmo      <= 1'b0;
        end else begin
            state    <= state_n;
            count    <= count_n;
            resp_acc <= resp_n;
            proto    <= proto_n;
            reject   <= reject_n;
            tmo      <= tmo_n;
        end
    end

    // Command fields are pure data; the state register decides when they matter.
    always_ff @(posedge aclk) begin
        if (take) begin
            lat_addr <= cmd_addr;
            lat_len  <= cmd_len;
            lat_size <= cmd_size;
            lat_id   <= cmd_id;
        end
    end

endmodule
